// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters (C, D) and the RAM.
// slave = arbiter side, master = requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16
);
  logic [1:0]        c_mem_cmd;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ready;
  logic [DATA_W-1:0] c_rdata;

  logic [1:0]        d_mem_cmd;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_write;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              owner;

  modport slave (
    input  c_mem_cmd, c_addr, c_wdata,
    input  d_mem_cmd, d_addr, d_wdata,
    input  ram_dout,
    output c_ready, c_rdata, d_ready, d_rdata,
    output ram_addr, ram_write, ram_din,
    output owner
  );

  modport master (
    output c_mem_cmd, c_addr, c_wdata,
    output d_mem_cmd, d_addr, d_wdata,
    output ram_dout,
    input  c_ready, c_rdata, d_ready, d_rdata,
    input  ram_addr, ram_write, ram_din,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read RAM between CPU port C and debug/loader port D (IDLE -> ACCESS -> RESP).
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention instead of C priority with a MAX_HOLD guard.
module mem_port_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic              w_next_owner;
  logic              r_c_ready;
  logic              r_d_ready;
  logic [DATA_W-1:0] r_c_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_c_req;
  logic              w_d_req;
  logic              w_pick_d;
  logic [1:0]        w_own_cmd;
  logic              w_ram_write;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_din;

  // cmd 2'b11 is neither a read nor a write, so it can never win a grant
  assign w_c_req   = (bus.c_mem_cmd == MREAD) || (bus.c_mem_cmd == MWRITE);
  assign w_d_req   = (bus.d_mem_cmd == MREAD) || (bus.d_mem_cmd == MWRITE);
  assign w_own_cmd = r_owner ? bus.d_mem_cmd : bus.c_mem_cmd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  assign w_pick_d = w_d_req && (!w_c_req || !r_owner);
`else
  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  logic [3:0] r_hold_cnt;
  logic [3:0] w_next_hold;

  assign w_pick_d = w_d_req && (!w_c_req || (r_hold_cnt == HOLD_MAX));

  // counts C grants that made a waiting D lose; any other decision resets it
  always_comb begin
    w_next_hold = r_hold_cnt;
    if (r_state == IDLE) begin
      if (w_c_req && w_d_req && !w_pick_d) begin
        if (r_hold_cnt != HOLD_MAX) w_next_hold = r_hold_cnt + 4'd1;
      end else begin
        w_next_hold = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_hold_cnt <= 4'd0;
    else        r_hold_cnt <= w_next_hold;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_owner <= w_next_owner;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_owner = r_owner;
    w_ram_write  = 1'b0;
    w_ram_addr   = '0;
    w_ram_din    = '0;
    case (r_state)
      IDLE: begin
        if (w_c_req || w_d_req) begin
          w_next_state = ACCESS;
          w_next_owner = w_pick_d;
        end
      end
      ACCESS: begin
        w_ram_addr   = r_owner ? bus.d_addr : bus.c_addr;
        w_ram_din    = r_owner ? bus.d_wdata : bus.c_wdata;
        w_ram_write  = (w_own_cmd == MWRITE);
        w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ready and read data are registered on the ACCESS -> RESP edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_c_ready <= (r_state == ACCESS) && !r_owner;
      r_d_ready <= (r_state == ACCESS) && r_owner;
      if ((r_state == ACCESS) && (w_own_cmd == MREAD)) begin
        if (r_owner) r_d_rdata <= bus.ram_dout;
        else         r_c_rdata <= bus.ram_dout;
      end
    end
  end

  assign bus.c_ready   = r_c_ready;
  assign bus.d_ready   = r_d_ready;
  assign bus.c_rdata   = r_c_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.ram_addr  = w_ram_addr;
  assign bus.ram_write = w_ram_write;
  assign bus.ram_din   = w_ram_din;
  assign bus.owner     = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random two-requester traffic,
// checked every cycle against a transaction-level schedule model with its own memory image.
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM image seen by the DUT: address captured mid-cycle so data is ready by the next rising edge
  logic [15:0] ram_mem [512];
  always @(negedge clk) bus.ram_dout = ram_mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_write) ram_mem[bus.ram_addr] = bus.ram_din;

  int total = 0;
  int bad = 0;

  // reference model: one scheduled transaction, next decision cycle, streak of C wins over waiting D
  logic [15:0] ref_mem [512];
  int          t = 0;
  logic        q_valid = 1'b0;
  int          q_cyc = 0;
  logic        q_d = 1'b0;
  logic        q_wr = 1'b0;
  logic [8:0]  q_addr = '0;
  logic [15:0] q_din = '0;
  int          next_free = 0;
  int          streak = 0;
  logic        m_owner = 1'b0;
  logic [15:0] m_c_rdata = '0;
  logic [15:0] m_d_rdata = '0;

  logic        o_rw, o_cr, o_dr, o_own;
  logic [8:0]  o_ra;
  logic [15:0] o_rd, o_crd, o_drd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic logic is_req(input logic [1:0] cmd);
    return (cmd == 2'b01) || (cmd == 2'b10);
  endfunction

  // one clock cycle: model the current inputs, sample/compare on the falling edge, advance past the next rise
  task automatic cycle();
    logic        e_rw, e_cr, e_dr, cr, dr, win_d;
    logic [8:0]  e_ra;
    logic [15:0] e_rd;
    e_rw = 1'b0; e_cr = 1'b0; e_dr = 1'b0; e_ra = '0; e_rd = '0;
    if (!reset) begin
      q_valid = 1'b0; next_free = t; streak = 0;
      m_owner = 1'b0; m_c_rdata = '0; m_d_rdata = '0;
    end else begin
      if (q_valid && t == q_cyc + 1) begin
        e_rw = q_wr; e_ra = q_addr; e_rd = q_din; m_owner = q_d;
      end else if (q_valid && t == q_cyc + 2) begin
        if (q_d) e_dr = 1'b1; else e_cr = 1'b1;
        if (q_wr) ref_mem[q_addr] = q_din;
        else if (q_d) m_d_rdata = ref_mem[q_addr];
        else m_c_rdata = ref_mem[q_addr];
        q_valid = 1'b0;
      end
      if (t >= next_free) begin
        cr = is_req(bus.c_mem_cmd);
        dr = is_req(bus.d_mem_cmd);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        win_d = dr && (!cr || !m_owner);
`else
        win_d = dr && (!cr || streak == MAX_HOLD);
`endif
        if (cr || dr) begin
          q_valid = 1'b1; q_cyc = t; q_d = win_d; next_free = t + 3;
          q_wr   = win_d ? (bus.d_mem_cmd == 2'b10) : (bus.c_mem_cmd == 2'b10);
          q_addr = win_d ? bus.d_addr : bus.c_addr;
          q_din  = win_d ? bus.d_wdata : bus.c_wdata;
        end
        if (cr && dr && !win_d) streak = (streak < MAX_HOLD) ? streak + 1 : MAX_HOLD;
        else streak = 0;
      end
    end
    @(negedge clk);
    o_rw = bus.ram_write; o_ra = bus.ram_addr; o_rd = bus.ram_din;
    o_cr = bus.c_ready; o_dr = bus.d_ready; o_own = bus.owner;
    o_crd = bus.c_rdata; o_drd = bus.d_rdata;
    chk("ram_write", 32'(o_rw), 32'(e_rw));
    chk("ram_addr", 32'(o_ra), 32'(e_ra));
    chk("ram_din", 32'(o_rd), 32'(e_rd));
    chk("c_ready", 32'(o_cr), 32'(e_cr));
    chk("d_ready", 32'(o_dr), 32'(e_dr));
    chk("c_rdata", 32'(o_crd), 32'(m_c_rdata));
    chk("d_rdata", 32'(o_drd), 32'(m_d_rdata));
    chk("owner", 32'(o_own), 32'(m_owner));
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic pick(output logic [1:0] cmd, output logic [8:0] a, output logic [15:0] d);
    int r;
    r = $urandom_range(0, 9);
    cmd = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    a = ($urandom_range(0, 7) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
    d = 16'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] exp_g;
    logic       c_pend, d_pend, w_before;
    int         n;
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 16'hA5A5 ^ 16'(i);
      ref_mem[i] = 16'hA5A5 ^ 16'(i);
    end
    bus.c_mem_cmd = 2'b00; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_mem_cmd = 2'b00; bus.d_addr = '0; bus.d_wdata = '0;
    bus.ram_dout = '0;

    cycle(); cycle();
    chk("rst_ready", 32'({o_cr, o_dr}), 32'd0);
    chk("rst_ram", 32'({o_rw, o_ra, o_rd}), 32'd0);
    chk("rst_rdata", 32'({o_crd, o_drd}), 32'd0);
    reset = 1'b1;
    cycle();

    // C write 0x005 <= 0xABCD
    bus.c_mem_cmd = 2'b10; bus.c_addr = 9'h005; bus.c_wdata = 16'hABCD;
    cycle(); w_before = o_rw;
    chk("wr_N_ram_write", 32'(w_before), 32'd0);
    cycle();
    chk("wr_N1_ram_write", 32'(o_rw), 32'd1);
    chk("wr_N1_ram_addr", 32'(o_ra), 32'h005);
    chk("wr_N1_ram_din", 32'(o_rd), 32'hABCD);
    cycle();
    chk("wr_N2_c_ready", 32'(o_cr), 32'd1);
    chk("wr_N2_d_ready", 32'(o_dr), 32'd0);
    bus.c_mem_cmd = 2'b00;
    cycle();

    // C read 0x005
    bus.c_mem_cmd = 2'b01;
    cycle(); cycle(); cycle();
    chk("rd_c_ready", 32'(o_cr), 32'd1);
    chk("rd_c_rdata", 32'(o_crd), 32'hABCD);
    chk("rd_d_rdata", 32'(o_drd), 32'h0);
    bus.c_mem_cmd = 2'b00;
    cycle();

    // D write 0x1FF aborted by reset during ACCESS
    bus.d_mem_cmd = 2'b10; bus.d_addr = 9'h1FF; bus.d_wdata = 16'h1234;
    cycle();
    chk("abort_access_write", 32'(bus.ram_write), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_write_drop", 32'(bus.ram_write), 32'd0);
    chk("abort_addr_drop", 32'(bus.ram_addr), 32'd0);
    bus.d_mem_cmd = 2'b00;
    cycle();
    chk("abort_no_d_ready", 32'(o_dr), 32'd0);
    cycle();
    chk("abort_no_d_ready2", 32'(o_dr), 32'd0);
    reset = 1'b1;
    cycle();
    bus.d_mem_cmd = 2'b01;
    cycle(); cycle(); cycle();
    chk("post_rst_d_ready", 32'(o_dr), 32'd1);
    chk("post_rst_d_rdata", 32'(o_drd), 32'hA45A);
    bus.d_mem_cmd = 2'b00;
    cycle(); cycle();

    // sustained contention, both reading
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_g = 10'b1010101010;
`else
    exp_g = 10'b1000010000;
`endif
    bus.c_mem_cmd = 2'b01; bus.c_addr = 9'h005;
    bus.d_mem_cmd = 2'b01; bus.d_addr = 9'h1FF;
    n = 0;
    for (int k = 0; k < 80 && n < 10; k++) begin
      cycle();
      if (o_cr || o_dr) begin
        chk($sformatf("grant%0d", n), 32'(o_dr), 32'(exp_g[n]));
        n++;
      end
    end
    chk("contention_grant_count", 32'(n), 32'd10);
    bus.c_mem_cmd = 2'b00; bus.d_mem_cmd = 2'b00;
    cycle(); cycle();

    // cmd 2'b11 is never served
    bus.c_mem_cmd = 2'b11; bus.c_addr = 9'h033; bus.c_wdata = 16'hFFFF;
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("cmd11_ram_write", 32'(o_rw), 32'd0);
      chk("cmd11_ready", 32'({o_cr, o_dr}), 32'd0);
    end
    bus.c_mem_cmd = 2'b00;
    cycle();

    // random traffic obeying the hold-until-ready handshake
    c_pend = 1'b0; d_pend = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (!c_pend || o_cr) begin
        pick(bus.c_mem_cmd, bus.c_addr, bus.c_wdata);
        c_pend = is_req(bus.c_mem_cmd);
      end
      if (!d_pend || o_dr) begin
        pick(bus.d_mem_cmd, bus.d_addr, bus.d_wdata);
        d_pend = is_req(bus.d_mem_cmd);
      end
      cycle();
      if (o_cr && o_dr) chk("both_ready", 32'd1, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port 16-bit RAM (9-bit address, synchronous read) between two requesters: the CPU load/store/fetch port (requester C) and a debug/loader port (requester D) that preloads or inspects memory while the CPU runs.
- Sits between cpu, the debug loader and RAM inside lab7_top.
- Sequences every access through arbitration, access and response phases.
- Uses fixed CPU priority with a starvation guard for D.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 16, RAM data width.
- MAX_HOLD, 4, max consecutive C grants while D is waiting; range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- c_mem_cmd  in  2  C command: 00 MNONE, 01 MREAD, 10 MWRITE, 11 treated as MNONE
- c_addr  in  ADDR_W  C address
- c_wdata  in  DATA_W  C write data
- c_ready  out  1  one-cycle completion pulse to C
- c_rdata  out  DATA_W  C read data, valid when c_ready=1 on a read
- d_mem_cmd, d_addr, d_wdata  in  2/ADDR_W/DATA_W  D request, same encoding as C
- d_ready  out  1  completion pulse to D
- d_rdata  out  DATA_W  D read data
- ram_addr  out  ADDR_W  RAM address
- ram_write  out  1  RAM write enable
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data, valid one cycle after the address
- owner  out  1  current/last grant: 0 = C, 1 = D

Behaviour:
- Reset (asynchronous, reset=0) takes effect immediately:
  - state=IDLE, owner=0, hold_cnt=0.
  - c_ready=d_ready=0, c_rdata=d_rdata=0.
  - ram_write=0, ram_addr=0, ram_din=0.
- Handshake:
  - A requester holds cmd/addr/wdata stable from assertion until it samples its ready=1.
  - It must present MNONE or a new command in the cycle after ready.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No valid request: stay in IDLE.
  - Otherwise pick a winner, register it into owner, go to ACCESS.
  - Winner rule:
    - Only one requesting: that one wins.
    - Both requesting: D wins if hold_cnt==MAX_HOLD, else C wins.
- hold_cnt:
  - Increments when C wins while D is requesting.
  - Clears when D wins or D is idle.
  - Saturates at MAX_HOLD.
- ACCESS, one cycle:
  - ram_addr and ram_din are driven combinationally from the owner's addr and wdata.
  - ram_write=1 iff the owner's cmd is MWRITE.
  - Go to RESP.
- RESP, one cycle:
  - Owner's ready=1, registered and asserted for exactly this cycle.
  - On a read, the owner's rdata is loaded from ram_dout at the ACCESS→RESP edge, so it is valid throughout RESP.
  - The non-owner's rdata holds its value.
  - Go to IDLE.
- Outside ACCESS: ram_write=0, ram_addr=0, ram_din=0.
- Latency:
  - Request first seen in IDLE at cycle N → ACCESS at N+1 → ready at N+2.
  - Next grant decision at N+3.
  - Sustained throughput is one access per 3 cycles.
- Boundary cases:
  - A command that changes mid-transaction violates the protocol. Behaviour is undefined but must not deadlock; the FSM always returns to IDLE.
  - cmd=11 never wins arbitration and never writes.
  - Address wrap: none. ram_addr is passed through unchanged.
  - Reset asserted during ACCESS drops ram_write the same cycle; no ready pulse is issued for the aborted access.
  - Both ready outputs are never high in the same cycle.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on contention the winner is the requester that did not win the previous grant (owner inverted). hold_cnt and MAX_HOLD are unused.
- Undefined: CPU priority with the MAX_HOLD starvation guard, as described in Behaviour.

Test Plan:
- Reset, then C MWRITE addr 9'h005 data 16'hABCD → ram_write=1 with ram_addr=5 exactly in cycle N+1; c_ready pulse at N+2; d_ready stays 0.
- C MREAD addr 5 after the write → c_rdata=16'hABCD with c_ready=1 at N+2; d_rdata unchanged at 0.
- C and D both continuously MREAD, MAX_HOLD=4 → grant sequence C,C,C,C,D,C,C,C,C,D; owner toggles accordingly.
- Same contention with MEM_ARB_ROUND_ROBIN_EN defined → grants alternate C,D,C,D starting with C.
- D MWRITE addr 9'h1FF data 16'h1234, with reset driven low during the ACCESS cycle → ram_write falls immediately; no d_ready; after reset release, a D read of 9'h1FF completes normally with d_ready.
- C cmd=2'b11 held for 10 cycles → FSM stays in IDLE, ram_write=0, no ready pulses.
